// File: rtl/hangman_pkg.sv
// Shared types and constants for the parametrised hangman core.
package hangman_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GUESS,
      CHECK,
      WIN,
      LOSE
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE   = 2'b00,
      RES_HIT    = 2'b01,
      RES_MISS   = 2'b10,
      RES_REPEAT = 2'b11
   } result_e;

   // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
   localparam int unsigned       LFSR_W    = 8;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/hangman_lfsr.sv
// Free-running Fibonacci LFSR; shifts left every cycle, feedback enters at bit 0.
module hangman_lfsr #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'('hB8)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/hangman_core_param.sv
// Hangman controller/datapath: word pick from LFSR, one guess per rising edge
// of next, single-cycle multi-position match, registered status outputs.
module hangman_core_param
   import hangman_pkg::*;
#(
   parameter int unsigned WORD_LEN  = 5,
   parameter int unsigned CHAR_W    = 5,
   parameter int unsigned MAX_TRIES = 7,
   parameter int unsigned NUM_WORDS = 4,
   parameter logic [NUM_WORDS*WORD_LEN*CHAR_W-1:0] WORDS = '0,
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       next,
   input  logic [CHAR_W-1:0]          guess_char,
   output logic [WORD_LEN-1:0]        guessed,
   output logic [TRY_W-1:0]           tries,
   output logic                       win,
   output logic                       lose,
   output logic [1:0]                 result,
   output logic                       busy,
   output logic [WORD_LEN*CHAR_W-1:0] word_reveal
);

   localparam int unsigned       WBITS    = WORD_LEN * CHAR_W;
   localparam logic [LFSR_W-1:0] IDX_MASK = LFSR_W'(NUM_WORDS - 1);

   state_e              state_q;
   logic                next_q;
   logic [WBITS-1:0]    word_q, reveal_q;
   logic [CHAR_W-1:0]   guess_q;
   logic [WORD_LEN-1:0] guessed_q;
   logic [TRY_W-1:0]    tries_q;
   logic                win_q, lose_q, busy_q;
   result_e             result_q;

   logic                rise_w;
   logic [LFSR_W-1:0]   lfsr_w;
   logic [31:0]         idx_w;
   logic [WBITS-1:0]    word_d;
   logic [WORD_LEN-1:0] match_w, fresh_w, merged_w;
   logic [TRY_W-1:0]    tries_inc;

   hangman_lfsr #(
      .WIDTH (LFSR_W),
      .SEED  (LFSR_SEED),
      .TAPS  (LFSR_TAPS)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_w)
   );

   assign rise_w = next & ~next_q;
   assign idx_w  = 32'(lfsr_w & IDX_MASK);
   assign word_d = WORDS[idx_w*WBITS +: WBITS];

   // Guessed bit i pairs with the CHAR_W field at bit i*CHAR_W, so letter 0
   // (MS field) lands on guessed[WORD_LEN-1] without any index reversal.
   for (genvar i = 0; i < WORD_LEN; i++) begin : g_match
      assign match_w[i] = (word_q[i*CHAR_W +: CHAR_W] == guess_q);
   end

   assign fresh_w   = match_w & ~guessed_q;
   assign merged_w  = guessed_q | match_w;
   assign tries_inc = tries_q + TRY_W'(1);

   always_ff @(posedge clk) begin
      // Tracks the button even in reset, so a press held across reset release is not an edge
      next_q <= next;
      if (reset) begin
         state_q   <= IDLE;
         word_q    <= '0;
         guess_q   <= '0;
         guessed_q <= '0;
         tries_q   <= '0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
         busy_q    <= 1'b0;
         reveal_q  <= '0;
         result_q  <= RES_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_w) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               word_q    <= word_d;
               guessed_q <= '0;
               tries_q   <= '0;
               win_q     <= 1'b0;
               lose_q    <= 1'b0;
               reveal_q  <= '0;
               result_q  <= RES_NONE;
               busy_q    <= 1'b0;
               state_q   <= GUESS;
            end
            GUESS: begin
               if (rise_w) begin
                  guess_q <= guess_char;
                  busy_q  <= 1'b1;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               busy_q  <= 1'b0;
               state_q <= GUESS;
               if (match_w == '0) begin
                  result_q <= RES_MISS;
                  if (tries_q != TRY_W'(MAX_TRIES)) begin
                     tries_q <= tries_inc;
                  end
                  if (tries_inc == TRY_W'(MAX_TRIES)) begin
                     lose_q   <= 1'b1;
                     reveal_q <= word_q;
                     state_q  <= LOSE;
                  end
               end else if (fresh_w == '0) begin
                  result_q <= RES_REPEAT;
               end else begin
                  guessed_q <= merged_w;
                  result_q  <= RES_HIT;
                  if (merged_w == '1) begin
                     win_q    <= 1'b1;
                     reveal_q <= word_q;
                     state_q  <= WIN;
                  end
               end
            end
            WIN, LOSE: begin
               if (rise_w) begin
                  win_q    <= 1'b0;
                  lose_q   <= 1'b0;
                  reveal_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= LOAD;
               end
            end
            default: begin
               win_q    <= 1'b0;
               lose_q   <= 1'b0;
               busy_q   <= 1'b0;
               reveal_q <= '0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign guessed     = guessed_q;
   assign tries       = tries_q;
   assign win         = win_q;
   assign lose        = lose_q;
   assign result      = result_q;
   assign busy        = busy_q;
   assign word_reveal = reveal_q;

endmodule

// File: tb/tb_hangman_core_param.sv
// Self-checking bench for hangman_core_param: game-level reference model plus
// directed scenarios and a randomized button/letter/reset phase.
module tb_hangman_core_param;

   localparam int WL = 5;
   localparam int CW = 5;
   localparam int MT = 7;
   localparam int NW = 2;
   localparam logic [NW*WL*CW-1:0] TB_WORDS =
      {5'd1, 5'd1, 5'd2, 5'd3, 5'd1, 5'd13, 5'd14, 5'd19, 5'd17, 5'd5};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          next = 1'b0;
   logic [CW-1:0] guess_char = '0;
   logic [WL-1:0] guessed;
   logic [2:0]    tries;
   logic          win, lose, busy;
   logic [1:0]    result;
   logic [WL*CW-1:0] word_reveal;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hangman_core_param #(
      .WORD_LEN  (WL),
      .CHAR_W    (CW),
      .MAX_TRIES (MT),
      .NUM_WORDS (NW),
      .WORDS     (TB_WORDS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .next        (next),
      .guess_char  (guess_char),
      .guessed     (guessed),
      .tries       (tries),
      .win         (win),
      .lose        (lose),
      .result      (result),
      .busy        (busy),
      .word_reveal (word_reveal)
   );

   // ---------------- reference model (game level) ----------------
   typedef enum int {PH_IDLE, PH_LOAD, PH_PLAY, PH_JUDGE, PH_WON, PH_LOST} phase_e;
   phase_e ph = PH_IDLE;
   int  lf = 1;
   bit  prev_nx = 1'b0;
   bit  m_valid = 1'b0;
   int  cur_word = 0;
   bit  rev[WL];
   int  m_tries = 0;
   int  m_res = 0;
   int  pend = 0;
   int  words[NW][WL] = '{'{13, 14, 19, 17, 5}, '{1, 1, 2, 3, 1}};

   function automatic int lfsr_next(input int v);
      int fb;
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      return ((v << 1) | fb) & 255;
   endfunction

   task automatic model_step();
      bit rise;
      int hits, fresh, shown;
      rise = next && !prev_nx;
      prev_nx = next;
      if (reset) begin
         ph = PH_IDLE; lf = 1; m_tries = 0; m_res = 0;
         foreach (rev[i]) rev[i] = 1'b0;
         m_valid = 1'b1;
         return;
      end
      case (ph)
         PH_IDLE, PH_WON, PH_LOST: if (rise) ph = PH_LOAD;
         PH_LOAD: begin
            cur_word = lf % NW;
            foreach (rev[i]) rev[i] = 1'b0;
            m_tries = 0; m_res = 0;
            ph = PH_PLAY;
         end
         PH_PLAY: if (rise) begin pend = int'(guess_char); ph = PH_JUDGE; end
         PH_JUDGE: begin
            hits = 0; fresh = 0; shown = 0;
            for (int i = 0; i < WL; i++) begin
               if (words[cur_word][i] == pend) begin
                  hits++;
                  if (!rev[i]) fresh++;
               end
            end
            ph = PH_PLAY;
            if (hits == 0) begin
               m_res = 2;
               if (m_tries < MT) m_tries++;
               if (m_tries == MT) ph = PH_LOST;
            end else if (fresh == 0) begin
               m_res = 3;
            end else begin
               m_res = 1;
               for (int i = 0; i < WL; i++)
                  if (words[cur_word][i] == pend) rev[i] = 1'b1;
               for (int i = 0; i < WL; i++) if (rev[i]) shown++;
               if (shown == WL) ph = PH_WON;
            end
         end
         default: ph = PH_IDLE;
      endcase
      lf = lfsr_next(lf);
   endtask

   function automatic logic [63:0] exp_guessed();
      logic [63:0] g = '0;
      for (int i = 0; i < WL; i++) if (rev[i]) g[WL-1-i] = 1'b1;
      return g;
   endfunction

   function automatic logic [63:0] exp_reveal();
      logic [63:0] r = '0;
      if (ph == PH_WON || ph == PH_LOST)
         for (int i = 0; i < WL; i++)
            r = r | (64'(words[cur_word][i]) << ((WL - 1 - i) * CW));
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("m_guessed", 64'(guessed), exp_guessed());
         chk("m_tries", 64'(tries), 64'(m_tries));
         chk("m_result", 64'(result), 64'(m_res));
         chk("m_win", 64'(win), 64'(ph == PH_WON));
         chk("m_lose", 64'(lose), 64'(ph == PH_LOST));
         chk("m_busy", 64'(busy), 64'(ph == PH_LOAD || ph == PH_JUDGE));
         chk("m_reveal", 64'(word_reveal), exp_reveal());
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic guess(input int c);
      guess_char = c[CW-1:0];
      next = 1'b1; tick(1);
      next = 1'b0; tick(1);
   endtask

   task automatic start_game(input int want);
      int waited = 0;
      while ((lfsr_next(lf) % NW) != want && waited < 600) begin
         tick(1);
         waited++;
      end
      if (waited >= 600) begin
         checks++; failures++;
         $display("FAIL start_game_timeout actual=%0d required<600", waited);
      end
      next = 1'b1; tick(1);
      chk("busy_in_load", 64'(busy), 64'd1);
      next = 1'b0; tick(1);
   endtask

   initial begin
      tick(3);
      chk("rst_guessed", 64'(guessed), 64'd0);
      chk("rst_reveal", 64'(word_reveal), 64'd0);
      reset = 1'b0;
      tick(2);

      // word 0: first hit, then win
      start_game(0);
      guess(13);
      chk("g13_guessed", 64'(guessed), 64'b10000);
      chk("g13_result", 64'(result), 64'b01);
      chk("g13_tries", 64'(tries), 64'd0);
      guess(14); guess(19); guess(17); guess(5);
      chk("win_flag", 64'(win), 64'd1);
      chk("win_guessed", 64'(guessed), 64'b11111);
      chk("win_reveal", 64'(word_reveal), 64'({5'd13, 5'd14, 5'd19, 5'd17, 5'd5}));
      tick(5);
      chk("win_held", 64'(win), 64'd1);

      // word 1: duplicate letters, repeat, then lose
      start_game(1);
      chk("restart_win", 64'(win), 64'd0);
      chk("restart_guessed", 64'(guessed), 64'd0);
      guess(1);
      chk("dup_guessed", 64'(guessed), 64'b11001);
      chk("dup_result", 64'(result), 64'b01);
      guess(1);
      chk("rep_result", 64'(result), 64'b11);
      chk("rep_guessed", 64'(guessed), 64'b11001);
      chk("rep_tries", 64'(tries), 64'd0);
      for (int k = 1; k <= MT; k++) begin
         guess(3 + k);
         chk("miss_tries", 64'(tries), 64'(k));
         chk("miss_result", 64'(result), 64'b10);
      end
      chk("lose_flag", 64'(lose), 64'd1);
      chk("lose_reveal", 64'(word_reveal), 64'({5'd1, 5'd1, 5'd2, 5'd3, 5'd1}));

      // new game from LOSE, then next held high for 20 cycles
      start_game(0);
      chk("relose_lose", 64'(lose), 64'd0);
      chk("relose_tries", 64'(tries), 64'd0);
      guess_char = 5'd14;
      next = 1'b1; tick(1);
      chk("busy_check", 64'(busy), 64'd1);
      tick(19);
      next = 1'b0; tick(2);
      chk("held_guessed", 64'(guessed), 64'b01000);
      chk("held_result", 64'(result), 64'b01);

      // reset in CHECK with six misses, next held across reset release
      guess(4); guess(6); guess(7); guess(8); guess(9); guess(10);
      chk("six_tries", 64'(tries), 64'd6);
      guess_char = 5'd11;
      next = 1'b1; tick(1);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b1; tick(1);
      chk("midrst_tries", 64'(tries), 64'd0);
      chk("midrst_guessed", 64'(guessed), 64'd0);
      chk("midrst_result", 64'(result), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      tick(2);
      reset = 1'b0; tick(5);
      chk("held_rst_busy", 64'(busy), 64'd0);
      next = 1'b0; tick(1);
      start_game(1);

      // randomized buttons, letters and occasional reset
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 2) == 0) next = ~next;
         guess_char = CW'($urandom_range(0, 20));
         reset = ($urandom_range(0, 399) == 0);
         tick(1);
      end
      reset = 1'b0; next = 1'b0;
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hangman_core_param.md
Name: hangman_core_param

Overview:
- Parametrised successor to the fixed 5-letter hangman controller/datapath.
- Holds a configurable word list. Picks a word per game from a free-running LFSR and accepts one guess per rising edge of `next`.
- Marks every position matching the guess in a single check cycle, so duplicate letters are handled. A repeated correct guess costs no try.
- Reports tries used and reveals the word at game end. Sits between the Caravel IO wrapper and pad logic, with all state fully registered.

Parameters:
- WORD_LEN, 5, letters per word.
- CHAR_W, 5, bits per letter code.
- MAX_TRIES, 7, wrong guesses allowed before LOSE (1..255).
- NUM_WORDS, 4, words in list; power of two, at least 2.
- WORDS, {NUM_WORDS*WORD_LEN*CHAR_W bits}, packed word list. Word k occupies the k-th WORD_LEN*CHAR_W slice from the LSB. Letter 0 of each word is its most significant CHAR_W field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- next  in  1  level button; only rising edges act
- guess_char  in  CHAR_W  letter code, sampled on the cycle a next edge is detected
- guessed  out  WORD_LEN  bit i set = letter i revealed (bit WORD_LEN-1 = letter 0)
- tries  out  TRY_W=$clog2(MAX_TRIES+1)  wrong guesses so far
- win  out  1  high in WIN
- lose  out  1  high in LOSE
- result  out  2  last check: 00 none, 01 hit, 10 miss, 11 repeat
- busy  out  1  high in LOAD and CHECK (next edges ignored)
- word_reveal  out  WORD_LEN*CHAR_W  current word in WIN/LOSE, else 0

Behaviour:
- Reset values:
  - state IDLE; next_q=0.
  - guessed=0, tries=0, win=0, lose=0, result=00, busy=0, word_reveal=0.
  - LFSR=8'h01.
- Edge detect: next_q<=next every cycle; edge = next & ~next_q.
  - `next` held high through reset release produces no edge until it drops and rises again.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle after reset. Word index = lfsr[$clog2(NUM_WORDS)-1:0] sampled in LOAD.
- States:
  - IDLE: on edge -> LOAD.
  - LOAD (1 cycle):
    - word_q <= WORDS[index]; guessed<=0; tries<=0; win<=0; lose<=0; result<=00.
    - -> GUESS.
  - GUESS: on edge, guess_q<=guess_char -> CHECK.
  - CHECK (1 cycle): match[i] = (word_q letter i == guess_q); new = match & ~guessed.
    - match==0: tries<=tries+1, result<=10. If tries+1==MAX_TRIES -> LOSE, else -> GUESS.
    - match!=0 and new==0: result<=11, no change -> GUESS.
    - Otherwise: guessed<=guessed|match, result<=01. If (guessed|match) is all ones -> WIN, else -> GUESS.
  - WIN/LOSE: win or lose held high, word_reveal=word_q. On edge -> LOAD (new game).
- Latency: edge detected in cycle N (GUESS) -> CHECK in N+1 -> guessed/tries/result/win/lose visible in N+2.
- Edges arriving during LOAD or CHECK are dropped, not queued.
- Repeated wrong guesses each cost a try; no miss history is kept.
- tries saturates at MAX_TRIES; it is never incremented outside CHECK.
- Reset mid-game (any state) returns to the reset values on the next clock edge.
- Unreachable state encodings -> IDLE.

Decomposition:
- Package hangman_pkg:
  - state enum {IDLE, LOAD, GUESS, CHECK, WIN, LOSE};
  - result codes RES_NONE/HIT/MISS/REPEAT;
  - LFSR seed and tap constants.
- Sub-module hangman_lfsr (width param, seed param, clk/reset, q output).
- Compare/update logic stays in the core; one generate loop over WORD_LEN.

Test Plan:
- Reset, one edge, LOAD. The bench model predicts the index; with NUM_WORDS=2 and word 0 = {13,14,19,17,5}, guess 13 -> guessed=10000, result=01, tries=0, two cycles after the edge.
- Word {1,1,2,3,1}: guess 1 -> guessed=11001 in one check; guess 1 again -> result=11, guessed=11001, tries unchanged.
- Seven distinct wrong guesses (MAX_TRIES=7) -> tries 1..7, lose=1 after the 7th, word_reveal equals the word. Next edge -> LOAD clears lose and tries.
- Guess all letters of {13,14,19,17,5} -> win=1 after the last CHECK. Further edges in WIN restart the game; no edges leave win=1.
- `next` held high for 20 cycles, and a second edge during CHECK -> exactly one guess processed; busy=1 during CHECK.
- Assert reset in CHECK with tries=6 -> next cycle all outputs at reset values and state IDLE. `next` held high across reset release -> no game start until re-pressed.
